// File: rtl/unidad_control_multiciclo_if.sv
// unidad_control_multiciclo_if: opcode/memory handshake in, datapath and memory control out
interface unidad_control_multiciclo_if;
  logic [5:0] opcode;
  logic       mem_listo;
  logic [1:0] operacion_alu;
  logic       pc_escribe;
  logic       pc_escribe_cond;
  logic [1:0] pc_fuente;
  logic       i_o_d;
  logic       mem_lee;
  logic       mem_escribe;
  logic       ir_escribe;
  logic       mem_a_reg;
  logic       reg_dst;
  logic       reg_escribe;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       instr_ilegal;
  logic       error_memoria;
  logic [3:0] estado;
  modport master (
    input  opcode, mem_listo,
    output operacion_alu, pc_escribe, pc_escribe_cond, pc_fuente, i_o_d, mem_lee,
           mem_escribe, ir_escribe, mem_a_reg, reg_dst, reg_escribe, alu_src_a,
           alu_src_b, instr_ilegal, error_memoria, estado
  );
  modport slave (
    output opcode, mem_listo,
    input  operacion_alu, pc_escribe, pc_escribe_cond, pc_fuente, i_o_d, mem_lee,
           mem_escribe, ir_escribe, mem_a_reg, reg_dst, reg_escribe, alu_src_a,
           alu_src_b, instr_ilegal, error_memoria, estado
  );
endinterface

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle MIPS main control FSM with memory-ready timeout
module unidad_control_multiciclo #(
  parameter int TIEMPO_ESPERA = 15
) (
  input logic clk,
  input logic rst_n,
  unidad_control_multiciclo_if.master bus
);
  typedef enum logic [3:0] {
    INICIO, FETCH, DECODE, MEM_DIR, MEM_LEE, MEM_WB, MEM_ESC, EJEC_R,
    R_WB, BEQ, SALTO, ADDI_EJEC, ADDI_WB, ILEGAL, ERROR_MEM
  } estado_t;
  estado_t st, nx;
  logic [7:0] cnt;
  logic ml, agotado;
  assign ml = bus.mem_listo;
  // cnt holds the cycles already waited, so the TIEMPO_ESPERA-th miss sees TIEMPO_ESPERA-1
  assign agotado = !ml && cnt == 8'(TIEMPO_ESPERA - 1);
  always_comb begin
    nx = INICIO;
    case (st)
      INICIO:    nx = FETCH;
      FETCH:     nx = ml ? DECODE : agotado ? ERROR_MEM : FETCH;
      DECODE:    nx = bus.opcode == 6'b000000 ? EJEC_R :
                      (bus.opcode == 6'b100011 || bus.opcode == 6'b101011) ? MEM_DIR :
                      bus.opcode == 6'b000100 ? BEQ :
                      bus.opcode == 6'b000010 ? SALTO :
                      bus.opcode == 6'b001000 ? ADDI_EJEC : ILEGAL;
      MEM_DIR:   nx = bus.opcode == 6'b100011 ? MEM_LEE : MEM_ESC;
      MEM_LEE:   nx = ml ? MEM_WB : agotado ? ERROR_MEM : MEM_LEE;
      MEM_ESC:   nx = ml ? FETCH : agotado ? ERROR_MEM : MEM_ESC;
      EJEC_R:    nx = R_WB;
      ADDI_EJEC: nx = ADDI_WB;
      MEM_WB, R_WB, BEQ, SALTO, ADDI_WB, ILEGAL, ERROR_MEM: nx = FETCH;
      default:   nx = INICIO;
    endcase
  end
  // only wait states ever stay put, so any state change is an entry that clears the counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= INICIO;
      cnt <= '0;
    end else begin
      st  <= nx;
      cnt <= nx == st ? cnt + 8'd1 : '0;
    end
  assign bus.operacion_alu   = st == EJEC_R ? 2'b10 : st == BEQ ? 2'b01 : 2'b00;
  assign bus.pc_escribe      = (st == FETCH && ml) || st == SALTO;
  assign bus.pc_escribe_cond = st == BEQ;
  assign bus.pc_fuente       = st == SALTO ? 2'b10 : st == BEQ ? 2'b01 : 2'b00;
  assign bus.i_o_d           = st == MEM_LEE || st == MEM_ESC;
  assign bus.mem_lee         = st == FETCH || st == MEM_LEE;
  assign bus.mem_escribe     = st == MEM_ESC;
  assign bus.ir_escribe      = st == FETCH && ml;
  assign bus.mem_a_reg       = st == MEM_WB;
  assign bus.reg_dst         = st == R_WB;
  assign bus.reg_escribe     = st == MEM_WB || st == R_WB || st == ADDI_WB;
  assign bus.alu_src_a       = st == MEM_DIR || st == EJEC_R || st == BEQ || st == ADDI_EJEC;
  assign bus.alu_src_b       = st == FETCH ? 2'b01 : st == DECODE ? 2'b11 :
                               (st == MEM_DIR || st == ADDI_EJEC) ? 2'b10 : 2'b00;
  assign bus.instr_ilegal    = st == ILEGAL;
  assign bus.error_memoria   = st == ERROR_MEM;
  assign bus.estado          = st;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: directed and random instruction streams against a route-table model
module tb_unidad_control_multiciclo;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n;
  unidad_control_multiciclo_if bus();
  unidad_control_multiciclo #(.TIEMPO_ESPERA(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int exp_st = 0;
  int w = 0;
  int q[$];
  int pct = 100;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [17:0] salidas(input int s, input logic ml);
    logic [1:0] op, pf, sb;
    logic pe, pc, iod, rdm, me, ir, mr, rd, re, sa, il, er;
    {op, pf, sb} = '0;
    {pe, pc, iod, rdm, me, ir, mr, rd, re, sa, il, er} = '0;
    case (s)
      1:  begin rdm = 1; sb = 2'b01; ir = ml; pe = ml; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin rdm = 1; iod = 1; end
      5:  begin re = 1; mr = 1; end
      6:  begin iod = 1; me = 1; end
      7:  begin sa = 1; op = 2'b10; end
      8:  begin re = 1; rd = 1; end
      9:  begin sa = 1; op = 2'b01; pc = 1; pf = 2'b01; end
      10: begin pe = 1; pf = 2'b10; end
      11: begin sa = 1; sb = 2'b10; end
      12: re = 1;
      13: il = 1;
      14: er = 1;
      default: ;
    endcase
    return {op, pe, pc, pf, iod, rdm, me, ir, mr, rd, re, sa, sb, il, er};
  endfunction
  function automatic logic [17:0] dut_salidas();
    return {bus.operacion_alu, bus.pc_escribe, bus.pc_escribe_cond, bus.pc_fuente, bus.i_o_d,
            bus.mem_lee, bus.mem_escribe, bus.ir_escribe, bus.mem_a_reg, bus.reg_dst,
            bus.reg_escribe, bus.alu_src_a, bus.alu_src_b, bus.instr_ilegal, bus.error_memoria};
  endfunction
  task automatic avanza(input logic ml);
    int prev = exp_st;
    case (exp_st)
      0: exp_st = 1;
      1, 4, 6:
        if (ml) begin
          if (exp_st == 1) exp_st = 2;
          else if (q.size() > 0) exp_st = q.pop_front();
          else exp_st = 1;
        end else begin
          w++;
          if (w == T) begin exp_st = 14; q.delete(); end
        end
      2: begin
        case (bus.opcode)
          6'b000000: q = '{7, 8};
          6'b100011: q = '{3, 4, 5};
          6'b101011: q = '{3, 6};
          6'b000100: q = '{9};
          6'b000010: q = '{10};
          6'b001000: q = '{11, 12};
          default:   q = '{13};
        endcase
        exp_st = q.pop_front();
      end
      default: exp_st = q.size() > 0 ? q.pop_front() : 1;
    endcase
    if (exp_st != prev) w = 0;
  endtask
  task automatic ciclo(input logic ml);
    @(negedge clk);
    bus.mem_listo = ml;
    #1;
    chk("estado", 32'(bus.estado), 32'(exp_st));
    chk($sformatf("salidas_e%0d", exp_st), 32'(dut_salidas()), 32'(salidas(exp_st, ml)));
    avanza(ml);
  endtask
  task automatic ciclos(input int n, input logic ml);
    repeat (n) ciclo(ml);
  endtask
  task automatic reinicio();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_estado", 32'(bus.estado), 32'd0);
    chk("rst_salidas", 32'(dut_salidas()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_st = 0;
    w = 0;
    q.delete();
  endtask
  initial begin
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    rst_n = 1'b1;
    bus.opcode = 6'b000000;
    bus.mem_listo = 1'b0;
    reinicio();
    ciclos(5, 1'b1);
    bus.opcode = 6'b100011;
    ciclos(3, 1'b1);
    ciclos(3, 1'b0);
    ciclos(2, 1'b1);
    bus.opcode = 6'b000100;
    ciclos(3, 1'b1);
    bus.opcode = 6'b000010;
    ciclos(3, 1'b1);
    bus.opcode = 6'b111111;
    ciclos(3, 1'b1);
    bus.opcode = 6'b101011;
    ciclos(3, 1'b1);
    ciclos(5, 1'b0);
    ciclos(3, 1'b1);
    ciclos(3, 1'b0);
    ciclos(1, 1'b1);
    bus.opcode = 6'b001000;
    ciclos(4, 1'b1);
    ciclos(5, 1'b0);
    bus.opcode = 6'b100011;
    ciclos(5, 1'b1);
    reinicio();
    ciclos(2, 1'b1);
    ciclos(7, 1'b1);
    repeat (800) begin
      if (exp_st == 1 && w == 0) begin
        int k = $urandom_range(0, 7);
        bus.opcode = k == 7 ? 6'($urandom) : ops[k];
        pct = $urandom_range(0, 2) == 0 ? 20 : $urandom_range(0, 1) ? 60 : 95;
      end
      ciclo($urandom_range(0, 99) < pct);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
